// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - Parametrised UART receiver with per-word error flags and FWFT FIFO
//
// Receives asynchronous serial frames (start, DATA_BITS LSB first, optional
// parity, STOP_BITS stop bits) and queues {ferr, perr, data} words in a
// first-word-fall-through FIFO read through a valid/ready handshake.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   - every sample point takes the 2-of-3 majority of the synchronised
//               line at bit-timer values T-2, T-1 and T.
//   undefined - single sample of the synchronised line at T.
//
// Ports:
//   clk      in   single clock
//   rst_n    in   synchronous active-low reset
//   rxd      in   asynchronous serial input, idle high
//   rdata    out  head-of-FIFO data word
//   perr     out  parity error flag of head word (0 when PARITY = 0)
//   ferr     out  framing error flag of head word
//   rvalid   out  FIFO non-empty
//   rready   in   consumer accepts head word
//   overrun  out  one-cycle pulse when a completed frame is dropped (FIFO full)
//   count    out  current FIFO occupancy

module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rxd,
    output logic [DATA_BITS-1:0]        rdata,
    output logic                        perr,
    output logic                        ferr,
    output logic                        rvalid,
    input  logic                        rready,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int NW = $clog2(DATA_BITS + 1);   // counts data bits, reused for stop bits
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_BITS + 2;           // {ferr, perr, data}

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] CNT_ONE   = TW'(1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic [NW-1:0] NBIT_ONE  = NW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Line synchroniser; bit 2 is the oldest stage and the only one used.
    // ------------------------------------------------------------------
    logic [2:0]           r_sync;
    logic                 w_rxd_s;
    logic                 w_sample;

    assign w_rxd_s = r_sync[2];

`ifdef UART_RX_MAJORITY_EN
    // History of the two previous synchronised values. The bit timer advances
    // by one every cycle, so at cnt == T these hold the values seen at T-1
    // and T-2.
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rxd_s};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) |
                      (r_hist[1] & w_rxd_s)   |
                      (r_hist[0] & w_rxd_s);
`else
    assign w_sample = w_rxd_s;
`endif

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [TW-1:0]        r_cnt;
    logic [NW-1:0]        r_nbit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;

    logic                 w_bit_tick;
    logic                 w_par_xor;
    logic                 w_par_bad;
    logic                 w_stop_ferr;
    logic                 w_push;
    logic [EW-1:0]        w_push_word;

    assign w_bit_tick  = (r_cnt == BIT_LAST);
    assign w_par_xor   = (^r_shift) ^ w_sample;
    // Odd parity fails when the overall XOR is 0, even parity when it is 1.
    assign w_par_bad   = (PARITY == 1) ? ~w_par_xor : w_par_xor;
    assign w_stop_ferr = r_ferr | ~w_sample;

    // The final stop sample pushes directly, so the word lands on the same
    // edge that returns the receiver to IDLE.
    assign w_push      = (r_state == S_STOP) && w_bit_tick && (r_nbit == STOP_LAST);
    assign w_push_word = {w_stop_ferr, r_perr, r_shift};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 3'b111;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_nbit  <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], rxd};

            case (r_state)
                S_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end

                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (w_sample) begin
                            // Line back high at the start-bit centre: a glitch.
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_nbit  <= '0;
                            r_perr  <= 1'b0;
                            r_ferr  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                        if (r_nbit == DATA_LAST) begin
                            r_nbit  <= '0;
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_nbit <= r_nbit + NBIT_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_PARITY: begin
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        r_perr  <= w_par_bad;
                        r_nbit  <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (w_bit_tick) begin
                        r_cnt  <= '0;
                        r_ferr <= w_stop_ferr;
                        if (r_nbit == STOP_LAST) begin
                            r_nbit  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_nbit <= r_nbit + NBIT_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;

    logic          w_pop;
    logic          w_full;
    logic          w_wr;

    assign w_pop  = (r_count != '0) && rready;
    assign w_full = (r_count == FULL_CNT);
    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // only dropped when nothing is being read.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Memory is cleared so the head outputs read 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= w_push_word;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count   <= r_count + CW'(w_wr) - CW'(w_pop);
            r_overrun <= w_push && w_full && !w_pop;
        end
    end

    assign {ferr, perr, rdata} = r_mem[r_rptr];
    assign rvalid  = (r_count != '0);
    assign count   = r_count;
    assign overrun = r_overrun;

endmodule
